// File: rtl/gray_rx.sv
// Gray-code receiver: decodes each enabled sample to binary, checks that the
// stream advances one code step at a time, and tracks wraps and sequence errors.
module gray_rx #(
  parameter int W  = 3,
  parameter int CW = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          En,
  input  logic [W-1:0]  In,
  output logic [W-1:0]  Binary,
  output logic          Valid,
  output logic          Locked,
  output logic          Overflow,
  output logic          Error,
  output logic [CW-1:0] WrapCnt
);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  localparam logic [W-1:0]  BIN_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]  BIN_MAX  = {W{1'b1}};
  localparam logic [W-1:0]  BIN_ZERO = {W{1'b0}};
  localparam logic [CW-1:0] WRAP_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] WRAP_MAX = {CW{1'b1}};

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  state_t        r_state;
  logic [W-1:0]  r_binary;
  logic          r_valid;
  logic          r_locked;
  logic          r_overflow;
  logic          r_error;
  logic [CW-1:0] r_wrapcnt;

  state_t        w_state_nx;
  logic [W-1:0]  w_binary_nx;
  logic          w_valid_nx;
  logic          w_overflow_nx;
  logic          w_error_nx;
  logic [CW-1:0] w_wrapcnt_nx;
  logic [W-1:0]  w_dec;

  assign w_dec = gray2bin(In);

  // Next-state and next-output logic; everything holds unless a sample is accepted.
  always_comb begin
    w_state_nx    = r_state;
    w_binary_nx   = r_binary;
    w_valid_nx    = 1'b0;
    w_overflow_nx = r_overflow;
    w_error_nx    = r_error;
    w_wrapcnt_nx  = r_wrapcnt;
    if (En) begin
      case (r_state)
        ST_SYNC, ST_ERR: begin
          // Both waiting states lock onto the zero code only.
          if (In == BIN_ZERO) begin
            w_state_nx  = ST_LOCKED;
            w_binary_nx = BIN_ZERO;
            w_valid_nx  = 1'b1;
          end else begin
            w_state_nx  = r_state;
          end
        end
        ST_LOCKED: begin
          if (w_dec == r_binary + BIN_ONE) begin
            w_binary_nx = w_dec;
            w_valid_nx  = 1'b1;
            if (r_binary == BIN_MAX) begin
              w_overflow_nx = 1'b1;
              if (r_wrapcnt != WRAP_MAX) begin
                w_wrapcnt_nx = r_wrapcnt + WRAP_ONE;
              end else begin
                w_wrapcnt_nx = r_wrapcnt;
              end
            end else begin
              w_overflow_nx = r_overflow;
            end
          end else if (w_dec == r_binary) begin
            w_state_nx = ST_LOCKED;
          end else begin
            w_state_nx = ST_ERR;
            w_error_nx = 1'b1;
          end
        end
        default: begin
          w_state_nx = ST_SYNC;
        end
      endcase
    end else begin
      w_state_nx = r_state;
    end
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state    <= ST_SYNC;
      r_binary   <= BIN_ZERO;
      r_valid    <= 1'b0;
      r_locked   <= 1'b0;
      r_overflow <= 1'b0;
      r_error    <= 1'b0;
      r_wrapcnt  <= {CW{1'b0}};
    end else begin
      r_state    <= w_state_nx;
      r_binary   <= w_binary_nx;
      r_valid    <= w_valid_nx;
      r_locked   <= (w_state_nx == ST_LOCKED);
      r_overflow <= w_overflow_nx;
      r_error    <= w_error_nx;
      r_wrapcnt  <= w_wrapcnt_nx;
    end
  end

  assign Binary   = r_binary;
  assign Valid    = r_valid;
  assign Locked   = r_locked;
  assign Overflow = r_overflow;
  assign Error    = r_error;
  assign WrapCnt  = r_wrapcnt;

endmodule
